// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed 7-segment driver for a packed-BCD count.
// Snapshots the count once per frame so a digit pair never tears.
module bcd_7seg_scan #(
  parameter int SCAN_DIV       = 4,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] count_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o,
  output logic       err_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, ONES, TENS} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       snap_q, snap_d;
  logic             err_q, err_d;
  logic             capture;
  logic [6:0]       segRaw;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h7E;
      4'd1:    decode = 7'h30;
      4'd2:    decode = 7'h6D;
      4'd3:    decode = 7'h79;
      4'd4:    decode = 7'h33;
      4'd5:    decode = 7'h5B;
      4'd6:    decode = 7'h5F;
      4'd7:    decode = 7'h70;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h7B;
      default: decode = 7'h4F;
    endcase
  endfunction

  function automatic logic isBad(input logic [7:0] v);
    isBad = (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      snap_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end

  // Captures happen only on leaving IDLE and at the TENS->ONES frame boundary.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    snap_d  = snap_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = ONES;
        div_d   = '0;
        capture = 1'b1;
      end
      ONES: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = TENS;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TENS: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ONES;
          capture = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      snap_d = count_i;
      err_d  = err_q | isBad(count_i);
    end
  end

  // Blanked leading tens still occupies its full slot.
  always_comb begin
    an_o   = 2'b00;
    segRaw = 7'h00;
    case (state_q)
      ONES: begin
        an_o   = 2'b01;
        segRaw = decode(snap_q[3:0]);
      end
      TENS: begin
        if (!(BLANK_LEADING && (snap_q[7:4] == 4'd0))) begin
          an_o   = 2'b10;
          segRaw = decode(snap_q[7:4]);
        end
      end
      default: ;
    endcase
    seg_o = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
    err_o = err_q;
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan: default build, no-blanking build,
// and a fast active-low build swept over every BCD value.
module tb_bcd_7seg_scan;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] count = 8'h00;

  logic [6:0] seg0, seg1, seg2;
  logic [1:0] an0, an1, an2;
  logic       err0, err1, err2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(resetN), .count_i(count),
    .seg_o(seg0), .an_o(an0), .err_o(err0));

  bcd_7seg_scan #(.SCAN_DIV(1), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(resetN), .count_i(count),
    .seg_o(seg1), .an_o(an1), .err_o(err1));

  bcd_7seg_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut2 (
    .clk_i(clk), .reset_n_i(resetN), .count_i(count),
    .seg_o(seg2), .an_o(an2), .err_o(err2));

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'd0:    segOf = 7'h7E;
      4'd1:    segOf = 7'h30;
      4'd2:    segOf = 7'h6D;
      4'd3:    segOf = 7'h79;
      4'd4:    segOf = 7'h33;
      4'd5:    segOf = 7'h5B;
      4'd6:    segOf = 7'h5F;
      4'd7:    segOf = 7'h70;
      4'd8:    segOf = 7'h7F;
      4'd9:    segOf = 7'h7B;
      default: segOf = 7'h4F;
    endcase
  endfunction

  task automatic applyStimulus(input logic [7:0] c, input logic rn);
    count  = c;
    resetN = rn;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Values are packed as {err, an[1:0], seg[6:0]}.
  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got err/an/seg=%b/%b/%h, want %b/%b/%h",
               tag, observed[9], observed[8:7], observed[6:0],
               expected[9], expected[8:7], expected[6:0]);
    end
  endtask

  task automatic runSlot(input string tag, input int n, input logic [9:0] expected);
    for (int i = 0; i < n; i++) begin
      stepClock();
      checkOutput(tag, {err0, an0, seg0}, expected);
    end
  endtask

  initial begin
    $display("[TB] starting bcd_7seg_scan bench");

    // 1: reset hold then free-running scan of 42
    applyStimulus(8'h42, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("t1_reset", {err0, an0, seg0}, {1'b0, 2'b00, 7'h00});
    end
    applyStimulus(8'h42, 1'b1);
    runSlot("t1_ones_a", 4, {1'b0, 2'b01, 7'h6D});
    runSlot("t1_tens_a", 4, {1'b0, 2'b10, 7'h33});
    runSlot("t1_ones_b", 4, {1'b0, 2'b01, 7'h6D});
    runSlot("t1_tens_b", 4, {1'b0, 2'b10, 7'h33});

    // 2: change mid-TENS is held off until the next frame
    runSlot("t2_ones", 4, {1'b0, 2'b01, 7'h6D});
    runSlot("t2_tens_pre", 2, {1'b0, 2'b10, 7'h33});
    applyStimulus(8'h57, 1'b1);
    runSlot("t2_tens_hold", 2, {1'b0, 2'b10, 7'h33});
    runSlot("t2_ones_new", 4, {1'b0, 2'b01, 7'h70});
    runSlot("t2_tens_new", 4, {1'b0, 2'b10, 7'h5B});

    // 3: leading-zero blanking, and the unblanked build
    applyStimulus(8'h05, 1'b0);
    stepClock();
    checkOutput("t3_reset", {err0, an0, seg0}, {1'b0, 2'b00, 7'h00});
    applyStimulus(8'h05, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("t3_ones", {err0, an0, seg0}, {1'b0, 2'b01, 7'h5B});
      checkOutput("t3_ones_nb", {err2, an2, seg2}, {1'b0, 2'b01, 7'h5B});
    end
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("t3_tens_blank", {err0, an0, seg0}, {1'b0, 2'b00, 7'h00});
      checkOutput("t3_tens_nb", {err2, an2, seg2}, {1'b0, 2'b10, 7'h7E});
    end

    // 4: invalid nibble sets a sticky error
    applyStimulus(8'h3C, 1'b0);
    stepClock();
    checkOutput("t4_reset", {err0, an0, seg0}, {1'b0, 2'b00, 7'h00});
    applyStimulus(8'h3C, 1'b1);
    runSlot("t4_ones_E", 1, {1'b1, 2'b01, 7'h4F});
    applyStimulus(8'h12, 1'b1);
    runSlot("t4_ones_E2", 3, {1'b1, 2'b01, 7'h4F});
    runSlot("t4_tens_3", 4, {1'b1, 2'b10, 7'h79});
    runSlot("t4_ones_2", 4, {1'b1, 2'b01, 7'h6D});
    runSlot("t4_tens_1", 4, {1'b1, 2'b10, 7'h30});
    runSlot("t4_ones_2b", 1, {1'b1, 2'b01, 7'h6D});
    applyStimulus(8'h12, 1'b0);
    runSlot("t4_err_clr", 1, {1'b0, 2'b00, 7'h00});

    // 5: reset mid-TENS restarts the divider
    applyStimulus(8'h12, 1'b1);
    runSlot("t5_ones", 4, {1'b0, 2'b01, 7'h6D});
    runSlot("t5_tens", 3, {1'b0, 2'b10, 7'h30});
    applyStimulus(8'h12, 1'b0);
    runSlot("t5_reset", 1, {1'b0, 2'b00, 7'h00});
    applyStimulus(8'h12, 1'b1);
    runSlot("t5_ones_full", 4, {1'b0, 2'b01, 7'h6D});
    runSlot("t5_tens_after", 1, {1'b0, 2'b10, 7'h30});

    // 6: SCAN_DIV=1 active-low sweep over all BCD values
    applyStimulus(8'h00, 1'b0);
    stepClock();
    checkOutput("t6_reset", {err1, an1, seg1}, {1'b0, 2'b00, 7'h7F});
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        logic [3:0] tn;
        logic [3:0] on;
        logic [9:0] expOnes;
        logic [9:0] expTens;
        tn = 4'(t);
        on = 4'(o);
        expOnes = {1'b0, 2'b01, ~segOf(on)};
        expTens = (tn == 4'd0) ? {1'b0, 2'b00, 7'h7F} : {1'b0, 2'b10, ~segOf(tn)};
        applyStimulus({tn, on}, 1'b1);
        for (int f = 0; f < 2; f++) begin
          stepClock();
          checkOutput("t6_ones", {err1, an1, seg1}, expOnes);
          stepClock();
          checkOutput("t6_tens", {err1, an1, seg1}, expTens);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
